// File: rtl/prg_saver.sv
// Streams a VIC-20 BASIC program out of main memory as a PRG file:
// 2-byte little-endian load address followed by the bytes between $2B/$2C and $2D/$2E.
module prg_saver #(
  parameter int unsigned RD_LAT   = 1,
  parameter logic [15:0] TOP_ADDR = 16'hA000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_din,
  output logic [24:0] up_addr,
  output logic [7:0]  up_data,
  output logic        up_valid,
  input  logic        up_ready,
  output logic        up_last
);

  typedef enum logic [3:0] {
    StIdle, StPtr, StCheck, StHdr0, StHdr1, StRd, StWait, StOut, StFin
  } state_e;

  localparam logic [1:0] LatLast = 2'(RD_LAT);

  state_e      state_q, state_d;
  logic [1:0]  ptr_idx_q, ptr_idx_d;
  logic        ptr_wait_q, ptr_wait_d;
  logic [1:0]  lat_q, lat_d;
  logic [15:0] s_ptr_q, s_ptr_d;
  logic [15:0] e_ptr_q, e_ptr_d;
  logic [15:0] end_q, end_d;
  logic [15:0] cur_q, cur_d;
  logic [7:0]  data_q, data_d;
  logic [24:0] offset_q, offset_d;
  logic        error_q, error_d;

  logic        xfer;
  logic        lat_done;
  logic        abort_hit;
  logic        last_byte;
  logic [15:0] e_clamp;

  assign xfer      = up_valid & up_ready;
  assign lat_done  = (lat_q == LatLast);
  assign abort_hit = abort && (state_q != StIdle) && (state_q != StFin);
  assign e_clamp   = (e_ptr_q > TOP_ADDR) ? TOP_ADDR : e_ptr_q;
  // In StOut end_q > cur_q always holds, so end_q - 1 cannot underflow.
  assign last_byte = (cur_q == end_q - 16'd1);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StPtr;
      StPtr:   if (ptr_wait_q && lat_done && (ptr_idx_q == 2'd3)) state_d = StCheck;
      StCheck: state_d = (e_clamp < s_ptr_q) ? StFin : StHdr0;
      StHdr0:  if (xfer) state_d = StHdr1;
      StHdr1:  if (xfer) state_d = (s_ptr_q == end_q) ? StFin : StRd;
      StRd:    state_d = StWait;
      StWait:  if (lat_done) state_d = StOut;
      StOut:   if (xfer) state_d = last_byte ? StFin : StRd;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_hit) state_d = StFin;
  end

  always_comb begin
    busy     = (state_q != StIdle) && (state_q != StFin);
    done     = (state_q == StFin);
    error    = error_q;
    mem_rd   = ((state_q == StPtr) && !ptr_wait_q) || (state_q == StRd);
    mem_addr = 16'h0000;
    if (state_q == StPtr) mem_addr = 16'h002B + {14'b0, ptr_idx_q};
    else if (state_q == StRd) mem_addr = cur_q;
    up_valid = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StOut);
    up_addr  = offset_q;
    up_data  = 8'h00;
    up_last  = 1'b0;
    unique case (state_q)
      StHdr0:  up_data = s_ptr_q[7:0];
      StHdr1:  begin
        up_data = s_ptr_q[15:8];
        up_last = (s_ptr_q == end_q);
      end
      StOut:   begin
        up_data = data_q;
        up_last = last_byte;
      end
      default: ;
    endcase
  end

  always_comb begin
    ptr_idx_d  = ptr_idx_q;
    ptr_wait_d = ptr_wait_q;
    lat_d      = lat_q;
    s_ptr_d    = s_ptr_q;
    e_ptr_d    = e_ptr_q;
    end_d      = end_q;
    cur_d      = cur_q;
    data_d     = data_q;
    offset_d   = offset_q;
    error_d    = error_q;
    unique case (state_q)
      StIdle: begin
        ptr_idx_d  = 2'd0;
        ptr_wait_d = 1'b0;
        lat_d      = 2'd0;
        offset_d   = 25'd0;
        if (start) error_d = 1'b0;
      end
      StPtr: begin
        if (!ptr_wait_q) begin
          ptr_wait_d = 1'b1;
          lat_d      = 2'd1;
        end else if (lat_done) begin
          unique case (ptr_idx_q)
            2'd0: s_ptr_d[7:0]  = mem_din;
            2'd1: s_ptr_d[15:8] = mem_din;
            2'd2: e_ptr_d[7:0]  = mem_din;
            2'd3: e_ptr_d[15:8] = mem_din;
            default: ;
          endcase
          ptr_idx_d  = ptr_idx_q + 2'd1;
          ptr_wait_d = 1'b0;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StCheck: begin
        end_d = e_clamp;
        cur_d = s_ptr_q;
        if (e_clamp < s_ptr_q) error_d = 1'b1;
      end
      StHdr0, StHdr1: if (xfer) offset_d = offset_q + 25'd1;
      StRd:   lat_d = 2'd1;
      StWait: begin
        if (lat_done) data_d = mem_din;
        else lat_d = lat_q + 2'd1;
      end
      StOut: begin
        if (xfer) begin
          offset_d = offset_q + 25'd1;
          cur_d    = cur_q + 16'd1;
        end
      end
      default: ;
    endcase
    if (abort_hit) error_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ptr_idx_q  <= 2'd0;
      ptr_wait_q <= 1'b0;
      lat_q      <= 2'd0;
      s_ptr_q    <= 16'h0000;
      e_ptr_q    <= 16'h0000;
      end_q      <= 16'h0000;
      cur_q      <= 16'h0000;
      data_q     <= 8'h00;
      offset_q   <= 25'd0;
      error_q    <= 1'b0;
    end else begin
      ptr_idx_q  <= ptr_idx_d;
      ptr_wait_q <= ptr_wait_d;
      lat_q      <= lat_d;
      s_ptr_q    <= s_ptr_d;
      e_ptr_q    <= e_ptr_d;
      end_q      <= end_d;
      cur_q      <= cur_d;
      data_q     <= data_d;
      offset_q   <= offset_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_prg_saver.sv
// Scoreboard bench for prg_saver: lane 0 runs RD_LAT=1, lane 1 runs RD_LAT=3,
// both reading one shared memory model.
module tb_prg_saver;

  localparam int Top = 'hA000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset_n, start, abort, busy, done, error, mem_rd, up_valid, up_ready, up_last;
  logic [15:0] mem_addr [2];
  logic [7:0]  mem_din [2];
  logic [24:0] up_addr [2];
  logic [7:0]  up_data [2];

  logic [7:0]  mem [65536];
  logic [7:0]  pipe [2][3];
  int          rd_cnt [2];
  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 0;

  // stream item {last, offset, data}; done item {error, reads}
  logic [33:0] exp_b0[$], exp_b1[$];
  logic [17:0] exp_d0[$], exp_d1[$];

  prg_saver #(.RD_LAT(1), .TOP_ADDR(16'hA000)) u_dut_l1 (
    .clk_sys(clk), .reset_n(reset_n[0]), .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .mem_addr(mem_addr[0]),
    .mem_rd(mem_rd[0]), .mem_din(mem_din[0]), .up_addr(up_addr[0]), .up_data(up_data[0]),
    .up_valid(up_valid[0]), .up_ready(up_ready[0]), .up_last(up_last[0])
  );

  prg_saver #(.RD_LAT(3), .TOP_ADDR(16'hA000)) u_dut_l3 (
    .clk_sys(clk), .reset_n(reset_n[1]), .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .mem_addr(mem_addr[1]),
    .mem_rd(mem_rd[1]), .mem_din(mem_din[1]), .up_addr(up_addr[1]), .up_data(up_data[1]),
    .up_valid(up_valid[1]), .up_ready(up_ready[1]), .up_last(up_last[1])
  );

  assign mem_din[0] = pipe[0][0];
  assign mem_din[1] = pipe[1][2];

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      pipe[l][0] <= mem_rd[l] ? mem[mem_addr[l]] : 8'h5A;
      pipe[l][1] <= pipe[l][0];
      pipe[l][2] <= pipe[l][1];
      if (start[l] && !busy[l]) rd_cnt[l] <= 0;
      else if (mem_rd[l]) rd_cnt[l] <= rd_cnt[l] + 1;
    end
  end

  task automatic push_b(input int l, input logic [33:0] v);
    if (l == 0) exp_b0.push_back(v); else exp_b1.push_back(v);
  endtask

  task automatic push_d(input int l, input logic [17:0] v);
    if (l == 0) exp_d0.push_back(v); else exp_d1.push_back(v);
  endtask

  // Monitor: compares every accepted byte and every done pulse against the queues.
  initial begin
    logic [1:0]  stall_prev;
    logic [1:0]  last_prev;
    logic [33:0] stall_val [2];
    logic [33:0] got, exp;
    logic [17:0] dexp;
    int          qsz;
    stall_prev = 2'b00;
    last_prev  = 2'b00;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        got = {up_last[l], up_addr[l], up_data[l]};
        if (up_valid[l]) begin
          checks++;
          if (mem_rd[l]) begin
            failures++;
            $display("FAIL rd_while_valid lane=%0d mem_rd=1 required=0", l);
          end
          if (stall_prev[l]) begin
            checks++;
            if (got != stall_val[l]) begin
              failures++;
              $display("FAIL stall_stable lane=%0d got=%h required=%h", l, got, stall_val[l]);
            end
          end
        end
        if (up_valid[l] && up_ready[l]) begin
          qsz = (l == 0) ? exp_b0.size() : exp_b1.size();
          checks++;
          if (qsz == 0) begin
            failures++;
            $display("FAIL unexpected_byte lane=%0d got=%h required=none", l, got);
          end else begin
            exp = (l == 0) ? exp_b0.pop_front() : exp_b1.pop_front();
            if (got != exp) begin
              failures++;
              $display("FAIL stream_byte lane=%0d got=%h required=%h", l, got, exp);
            end
          end
        end
        if (done[l]) begin
          qsz = (l == 0) ? exp_d0.size() : exp_d1.size();
          checks++;
          if (qsz == 0) begin
            failures++;
            $display("FAIL unexpected_done lane=%0d error=%0b required=no_done", l, error[l]);
          end else begin
            dexp = (l == 0) ? exp_d0.pop_front() : exp_d1.pop_front();
            checks++;
            if (error[l] != dexp[17]) begin
              failures++;
              $display("FAIL done_error lane=%0d got=%0b required=%0b", l, error[l], dexp[17]);
            end
            checks++;
            if (rd_cnt[l] != int'(dexp[16:0])) begin
              failures++;
              $display("FAIL mem_reads lane=%0d got=%0d required=%0d", l, rd_cnt[l],
                       int'(dexp[16:0]));
            end
            qsz = (l == 0) ? exp_b0.size() : exp_b1.size();
            checks++;
            if (qsz != 0) begin
              failures++;
              $display("FAIL missing_bytes lane=%0d left=%0d required=0", l, qsz);
              if (l == 0) exp_b0.delete(); else exp_b1.delete();
            end
            if (!dexp[17] && (dexp[16:0] != 17'd0)) begin
              checks++;
              if (!last_prev[l]) begin
                failures++;
                $display("FAIL done_after_last lane=%0d got=0 required=1", l);
              end
            end
          end
        end
        stall_prev[l] = up_valid[l] & ~up_ready[l];
        stall_val[l]  = got;
        last_prev[l]  = up_valid[l] & up_ready[l] & up_last[l];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: up_ready = 2'b11;
      1: up_ready = ~up_ready;
      2: up_ready = {2{($urandom_range(0, 3) != 0)}};
      default: ;
    endcase
  endtask

  task automatic check_reset_vals(input int l);
    logic [61:0] got;
    got = {busy[l], done[l], error[l], mem_rd[l], mem_addr[l], up_valid[l], up_last[l],
           up_data[l], up_addr[l], 8'h00};
    checks++;
    if (got != 62'd0) begin
      failures++;
      $display("FAIL reset_values lane=%0d got=%h required=0", l, got);
    end
  endtask

  // Reference: PRG = load address (LE) then memory[start .. min(end,TOP)-1].
  task automatic run_save(input int l, input int s, input int e, input bit poke, input bit aws);
    int ec, n, cycles, lat;
    lat = (l == 0) ? 1 : 3;
    mem[16'h002B] = 8'(s);
    mem[16'h002C] = 8'(s >> 8);
    mem[16'h002D] = 8'(e);
    mem[16'h002E] = 8'(e >> 8);
    ec = (e > Top) ? Top : e;
    if (ec < s) begin
      push_d(l, {1'b1, 17'd4});
    end else begin
      n = ec - s;
      push_b(l, {1'b0, 25'd0, 8'(s)});
      push_b(l, {(n == 0), 25'd1, 8'(s >> 8)});
      for (int i = 0; i < n; i++) push_b(l, {(i == n - 1), 25'(i + 2), mem[16'(s + i)]});
      push_d(l, {1'b0, 17'(4 + n)});
    end
    start[l] = 1'b1;
    abort[l] = aws;
    tick();
    start[l] = 1'b0;
    abort[l] = 1'b0;
    cycles = 0;
    while (!done[l] && cycles < 20000) begin
      start[l] = poke && (cycles == 3);
      tick();
      cycles++;
    end
    start[l] = 1'b0;
    if (!done[l]) begin
      checks++;
      failures++;
      $display("FAIL done_timeout lane=%0d cycles=%0d required=done", l, cycles);
    end else if (ec < s) begin
      checks++;
      if (cycles != 4 * (1 + lat) + 1) begin
        failures++;
        $display("FAIL error_latency lane=%0d got=%0d required=%0d", l, cycles,
                 4 * (1 + lat) + 1);
      end
    end
    tick();
  endtask

  initial begin
    int s, e, l, guard;
    reset_n = 2'b00;
    start = 2'b00;
    abort = 2'b00;
    up_ready = 2'b11;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    repeat (3) tick();
    check_reset_vals(0);
    check_reset_vals(1);
    reset_n = 2'b11;
    tick();

    mem[16'h1201] = 8'hAA; mem[16'h1202] = 8'hBB;
    mem[16'h1203] = 8'hCC; mem[16'h1204] = 8'hDD;
    run_save(0, 'h1201, 'h1205, 1'b0, 1'b0);
    run_save(0, 'h1201, 'h1201, 1'b0, 1'b0);
    run_save(0, 'h1201, 'h1100, 1'b0, 1'b0);
    run_save(1, 'h1201, 'h1100, 1'b0, 1'b0);
    ready_mode = 1;
    run_save(1, 'h1201, 'h1205, 1'b0, 1'b0);
    ready_mode = 0;
    run_save(0, 'h9FFE, 'hC000, 1'b0, 1'b0);
    run_save(1, 'h9FFE, 'hC000, 1'b0, 1'b0);
    run_save(0, 'h1201, 'h1205, 1'b1, 1'b0);
    run_save(0, 'h1201, 'h1205, 1'b0, 1'b1);

    // Abort while byte at offset 3 is stalled.
    push_b(0, {1'b0, 25'd0, 8'h01});
    push_b(0, {1'b0, 25'd1, 8'h12});
    push_b(0, {1'b0, 25'd2, 8'hAA});
    push_d(0, {1'b1, 17'd6});
    ready_mode = 3;
    up_ready = 2'b11;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    guard = 0;
    while (up_addr[0] != 25'd3 && guard < 100) begin tick(); guard++; end
    up_ready[0] = 1'b0;
    while (!up_valid[0] && guard < 200) begin tick(); guard++; end
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    checks++;
    if ({up_valid[0], done[0], error[0]} != 3'b011) begin
      failures++;
      $display("FAIL abort_response got=%b required=011", {up_valid[0], done[0], error[0]});
    end
    tick();

    // Reset while the first header byte is stalled: no done, reset outputs.
    up_ready = 2'b00;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    guard = 0;
    while (!up_valid[0] && guard < 100) begin tick(); guard++; end
    reset_n[0] = 1'b0;
    tick();
    check_reset_vals(0);
    reset_n[0] = 1'b1;
    up_ready = 2'b11;
    tick();
    tick();

    for (int it = 0; it < 40; it++) begin
      ready_mode = int'($urandom_range(0, 2));
      l = int'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin s = 'h1000 + int'($urandom_range(0, 'h6000)); e = s - 1 - int'($urandom_range(0, 200)); end
        1: begin s = Top - int'($urandom_range(0, 6)); e = Top + int'($urandom_range(0, 'h3000)); end
        default: begin s = 'h1000 + int'($urandom_range(0, 'h6000)); e = s + int'($urandom_range(0, 24)); end
      endcase
      run_save(l, s, e, 1'b0, 1'b0);
    end
    ready_mode = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
